fifo_wr_arbiter: RTL
====================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_SIZE, default 8, meaning the width of the requester data and the FIFO write data.
REQ-002 The block SHALL have parameter BURST, default 4, meaning the maximum consecutive grants to one requester while the other is requesting; legal range 1..15.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have ports req0 and req1, input, 1 bit each: the requester holds its write request until granted.
REQ-006 The block SHALL have ports data0 and data1, input, DATA_SIZE bits each: the requester write data, valid while its req is high.
REQ-007 The block SHALL have ports gnt0 and gnt1, output, 1 bit each: write accepted this cycle.
REQ-008 The block SHALL have port fifo_full, input, 1 bit: full flag from the 16x8 sync FIFO.
REQ-009 The block SHALL have port fifo_wr_en, output, 1 bit: drives the FIFO wr_en.
REQ-010 The block SHALL have port fifo_data_in, output, DATA_SIZE bits: drives the FIFO data_in.
REQ-011 The block SHALL have port owner, output, 2 bits: state code, IDLE=00, OWN0=01, OWN1=10.
REQ-012 The block SHALL have ports gnt_cnt0 and gnt_cnt1, output, 16 bits each: grant statistics counters (see Configuration).

Function
REQ-013 The block SHALL use state machine states IDLE, OWN0 and OWN1, and SHALL also keep registers burst_cnt (4 bits) and last (1 bit, the most recently granted requester).
REQ-014 The winner W SHALL be computed combinationally each cycle, as follows.
- No req high: no winner.
- Exactly one req high: that requester.
- Both req high, state OWNx and burst_cnt < BURST: x.
- Both req high, otherwise: the requester that is not last.
REQ-015 gnt_W SHALL be high only when W exists and fifo_full=0, with at most one gnt high in any cycle (same-cycle grant, zero latency).
REQ-016 fifo_wr_en SHALL equal gnt0|gnt1, and fifo_data_in SHALL equal data_W when granted and all-zeros otherwise.
REQ-017 On a grant the block SHALL set state to OWN_W and last to W, and SHALL set burst_cnt to burst_cnt+1 if W equals the current owner and to 1 otherwise.
REQ-018 When no req is high, the block SHALL go to state IDLE, clear burst_cnt to 0, and keep last unchanged.
REQ-019 When fifo_full=1 with a req pending, the block SHALL hold state, burst_cnt and last and issue no grant; arbitration resumes on the first cycle in which fifo_full=0.
REQ-020 A lone requester SHALL be granted every non-full cycle regardless of burst_cnt, with burst_cnt saturating at BURST.
REQ-021 A requester that deasserts req while owner SHALL lose ownership; if the other requester is requesting it SHALL be granted in that same cycle.

Reset
REQ-022 While reset=1 the block SHALL force state=IDLE, burst_cnt=0, last=1 (so requester 0 wins the first tie), gnt0=gnt1=0, fifo_wr_en=0, fifo_data_in=0, gnt_cnt0=gnt_cnt1=0.
REQ-023 Reset asserted mid-burst SHALL drop any grant immediately without waiting for a clock edge; after release, arbitration SHALL restart from the REQ-022 values.

Configuration
REQ-024 With macro FIFO_ARB_STATS_EN defined, gnt_cnt0 and gnt_cnt1 SHALL increment by 1 on each cycle their gnt is high, saturating at 16'hFFFF.
REQ-025 Without FIFO_ARB_STATS_EN, gnt_cnt0 and gnt_cnt1 SHALL be constant 0, no counter registers SHALL be inferred, and all other behaviour SHALL be unchanged.

Verification
REQ-026 Reset, then req0=1 alone with data0=8'hA5 and fifo_full=0 -> gnt0=1, fifo_wr_en=1, fifo_data_in=8'hA5 in the same cycle; owner=01 next cycle.
REQ-027 req0=req1=1 held for 12 cycles, BURST=4, fifo_full=0 -> grant pattern 0,0,0,0,1,1,1,1,0,0,0,0.
REQ-028 req0=req1=1 with fifo_full=1 for 3 cycles mid-burst (burst_cnt=2) -> no grants and owner held; after fifo_full=0, two more grants to the same owner, then a switch.
REQ-029 Assert reset during OWN1 with burst_cnt=3 -> gnt1 and fifo_wr_en fall without waiting for a clock edge; after release with both req high, the first grant goes to requester 0.
REQ-030 FIFO_ARB_STATS_EN defined, 10 grants to requester 0 and 6 to requester 1 -> gnt_cnt0=10, gnt_cnt1=6; macro undefined -> both counters read 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Two-requester write arbiter in front of a synchronous FIFO. Grants are
// issued combinationally (same cycle as the request). A requester keeps the
// FIFO for up to BURST consecutive writes while the other is also waiting.
// Ties with no current owner go to the requester that was not served last.
//
// Parameters:
//   DATA_SIZE - width of requester data and FIFO write data
//   BURST     - max consecutive grants to one requester under contention (1..15)
// Ports:
//   clk, reset           - clock, asynchronous active-high reset
//   req0/req1            - write requests, held until granted
//   data0/data1          - write data, valid while the matching req is high
//   gnt0/gnt1            - write accepted this cycle
//   fifo_full            - FIFO full flag; blocks all grants
//   fifo_wr_en           - FIFO write enable
//   fifo_data_in         - FIFO write data (zero when nothing is granted)
//   owner                - state code: IDLE=00, OWN0=01, OWN1=10
//   gnt_cnt0/gnt_cnt1    - saturating grant counters
// Optional feature:
//   FIFO_ARB_STATS_EN    - when defined, gnt_cnt0/1 count grants; otherwise 0
module fifo_wr_arbiter #(
   parameter int DATA_SIZE = 8,
   parameter int BURST     = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req0,
   input  logic                 req1,
   input  logic [DATA_SIZE-1:0] data0,
   input  logic [DATA_SIZE-1:0] data1,
   output logic                 gnt0,
   output logic                 gnt1,
   input  logic                 fifo_full,
   output logic                 fifo_wr_en,
   output logic [DATA_SIZE-1:0] fifo_data_in,
   output logic [1:0]           owner,
   output logic [15:0]          gnt_cnt0,
   output logic [15:0]          gnt_cnt1
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OWN0 = 2'b01,
      OWN1 = 2'b10
   } state_t;

   localparam logic [3:0] BURST_L = 4'(BURST);

   state_t     state;
   logic [3:0] burst_cnt;
   logic       last;

   logic any_req;
   logic burst_ok;
   logic win;       // 0 = requester 0, 1 = requester 1 (meaningful when any_req)
   logic grant;
   logic same_owner;

   always_comb begin
      any_req  = req0 | req1;
      burst_ok = burst_cnt < BURST_L;
      win      = 1'b0;
      if (req0 && !req1)
         win = 1'b0;
      else if (req1 && !req0)
         win = 1'b1;
      else if (state == OWN0 && burst_ok)
         win = 1'b0;
      else if (state == OWN1 && burst_ok)
         win = 1'b1;
      else
         win = ~last;
      // Reset is folded in so a grant drops the moment reset rises,
      // without waiting for the registers to clear on an edge.
      grant      = any_req && !fifo_full && !reset;
      same_owner = (win && state == OWN1) || (!win && state == OWN0);
   end

   assign gnt0         = grant && !win;
   assign gnt1         = grant && win;
   assign fifo_wr_en   = grant;
   assign fifo_data_in = grant ? (win ? data1 : data0) : '0;
   assign owner        = state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         burst_cnt <= 4'd0;
         last      <= 1'b1;   // requester 0 wins the first tie
      end else if (!any_req) begin
         state     <= IDLE;
         burst_cnt <= 4'd0;
      end else if (!fifo_full) begin
         state <= win ? OWN1 : OWN0;
         last  <= win;
         // A lone requester keeps winning past BURST; the count just sticks.
         if (same_owner)
            burst_cnt <= burst_ok ? burst_cnt + 4'd1 : burst_cnt;
         else
            burst_cnt <= 4'd1;
      end
      // fifo_full with a pending request: everything holds.
   end

`ifdef FIFO_ARB_STATS_EN
   logic [15:0] cnt0;
   logic [15:0] cnt1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt0 <= 16'd0;
         cnt1 <= 16'd0;
      end else begin
         if (gnt0 && cnt0 != 16'hFFFF) cnt0 <= cnt0 + 16'd1;
         if (gnt1 && cnt1 != 16'hFFFF) cnt1 <= cnt1 + 16'd1;
      end
   end

   assign gnt_cnt0 = cnt0;
   assign gnt_cnt1 = cnt1;
`else
   assign gnt_cnt0 = 16'd0;
   assign gnt_cnt1 = 16'd0;
`endif

endmodule
